// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank sampled in the clk domain; write frames update registers.
// Read-back on cipo is built only when SPI_READBACK_EN is defined.
module spi_reg_bank #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 err_count
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CntFrame = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CntSat   = CNT_W'(FRAME_W + 1);
    // Count value just before the rise that completes the address field.
    localparam logic [CNT_W-1:0] CntAddr  = CNT_W'(ADDR_W);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StOver} state_e;

    logic [2:0]                 sclk_sync_q;
    logic [1:0]                 copi_sync_q;
    logic [2:0]                 ncs_sync_q;
    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FRAME_W-1:0]         rx_q, rx_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                 err_q, err_d;

    logic                       sclk_rise;
    logic                       ncs_s;
    logic                       ncs_rise;
    logic                       ncs_fall;
    logic [FRAME_W-1:0]         rx_shift;
    logic                       rx_rw;
    logic [ADDR_W-1:0]          rx_addr;
    logic [DATA_W-1:0]          rx_data;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ncs_s     = ncs_sync_q[1];
    assign ncs_rise  = ncs_sync_q[1] & ~ncs_sync_q[2];
    assign ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];

    assign rx_shift = {rx_q[FRAME_W-2:0], copi_sync_q[1]};
    assign rx_rw    = rx_q[FRAME_W-1];
    assign rx_addr  = rx_q[FRAME_W-2 -: ADDR_W];
    assign rx_data  = rx_q[DATA_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_d       = err_q;

        // ncs rise takes priority over a coincident sclk rise, which is dropped.
        if (ncs_rise) begin
            state_d = StIdle;
            if (cnt_q == CntFrame) begin
                if (rx_rw && (32'(rx_addr) < NUM_REGS)) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (32'(rx_addr) == i) begin
                            regs_d[i*DATA_W +: DATA_W] = rx_data;
                        end
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = rx_addr;
                end
            end else if ((cnt_q != '0) && (err_q != 8'hff)) begin
                err_d = err_q + 8'd1;
            end
        end else if (ncs_fall) begin
            state_d = StAddr;
            cnt_d   = '0;
            rx_d    = '0;
        end else if ((state_q != StIdle) && sclk_rise) begin
            if (cnt_q != CntSat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q < CntFrame) begin
                rx_d = rx_shift;
            end
            case (state_q)
                StAddr:  if (cnt_q == CntAddr) state_d = StData;
                StData:  if (cnt_q == CntFrame) state_d = StOver;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            copi_sync_q <= 2'b00;
            ncs_sync_q  <= 3'b111;
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_q        <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= 8'h00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            copi_sync_q <= {copi_sync_q[0], copi};
            ncs_sync_q  <= {ncs_sync_q[1:0], ncs};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rd_data;
    logic              sclk_fall;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;

    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign lat_rw    = rx_shift[ADDR_W];
    assign lat_addr  = rx_shift[ADDR_W-1:0];

    // Out-of-range addresses read back as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(lat_addr) == i) begin
                rd_data = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        tx_d = tx_q;
        if (ncs_rise || ncs_fall) begin
            tx_d = '0;
        end else if ((state_q == StAddr) && sclk_rise && (cnt_q == CntAddr)) begin
            tx_d = lat_rw ? '0 : rd_data;
        end else if ((state_q == StData) && sclk_fall) begin
            tx_d = tx_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign cipo = ((state_q == StData) && !ncs_s) ? tx_q[DATA_W-1] : 1'b0;
`else
    assign cipo = 1'b0;
`endif

    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: bit-banged SPI frames against a register/error model
// with a queue of expected post-frame state and a queue of expected cipo bits.
module tb_spi_reg_bank;

    localparam int NREGS   = 5;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int REGS_W  = NREGS * DATA_W;
`ifdef SPI_READBACK_EN
    localparam bit ReadBack = 1'b1;
`else
    localparam bit ReadBack = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk  = 1'b0;
    logic              copi  = 1'b0;
    logic              ncs   = 1'b1;
    logic              cipo;
    logic [REGS_W-1:0] regs;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        err_count;

    spi_reg_bank #(
        .NUM_REGS (NREGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs),
        .cipo      (cipo),
        .regs      (regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cycles = 0;

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cycles++;

    typedef struct {
        logic [REGS_W-1:0] regs;
        logic [7:0]        err;
        logic [ADDR_W-1:0] addr;
        int                strobes;
    } exp_t;

    exp_t              exp_q[$];
    logic              exp_bits[$];
    logic [REGS_W-1:0] m_regs = '0;
    logic [7:0]        m_err  = 8'h00;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_strobes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         input int nclk);
        logic [15:0] f;
        exp_t        e;
        exp_t        got;
        logic        b;
        int          ai;
        f  = {rw, a, d};
        ai = int'(a);
        if (nclk == 16) begin
            if (rw && ai < NREGS) begin
                m_regs[ai*DATA_W +: DATA_W] = d;
                m_addr = a;
                m_strobes++;
            end
            if (!rw) begin
                for (int i = 0; i < DATA_W; i++) begin
                    exp_bits.push_back((ReadBack && ai < NREGS) ?
                                       m_regs[ai*DATA_W + (DATA_W-1-i)] : 1'b0);
                end
            end
        end else if (nclk != 0 && m_err != 8'hff) begin
            m_err = m_err + 8'd1;
        end
        e.regs = m_regs;
        e.err = m_err;
        e.addr = m_addr;
        e.strobes = m_strobes;
        exp_q.push_back(e);

        ncs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nclk; i++) begin
            copi = (i < 16) ? f[15-i] : 1'b0;
            wait_clk(6);
            sclk = 1'b1;
            wait_clk(5);
            // Data bits are presented from the address-completing rise onward.
            if (!rw && nclk == 16 && i >= 7 && i <= 14) begin
                b = exp_bits.pop_front();
                chk("cipo_bit", 64'(cipo), 64'(b));
            end
            wait_clk(1);
            sclk = 1'b0;
        end
        wait_clk(6);
        ncs = 1'b1;
        wait_clk(6);

        got = exp_q.pop_front();
        chk("regs", 64'(regs), 64'(got.regs));
        chk("err_count", 64'(err_count), 64'(got.err));
        chk("wr_addr", 64'(wr_addr), 64'(got.addr));
        chk("strobe_cycles", 64'(strobe_cycles), 64'(got.strobes));
        chk("cipo_idle", 64'(cipo), 64'd0);
    endtask

    initial begin
        logic [15:0] f;

        rst_n = 1'b0;
        wait_clk(3);
        chk("rst_regs", 64'(regs), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_strobe", 64'(wr_strobe), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_cipo", 64'(cipo), 64'd0);
        rst_n = 1'b1;
        wait_clk(4);

        frame(1'b1, 7'd0, 8'hA5, 16);
        frame(1'b1, 7'd5, 8'hFF, 16);
        frame(1'b0, 7'd0, 8'h00, 0);
        frame(1'b1, 7'd2, 8'h42, 15);
        frame(1'b1, 7'd2, 8'h42, 17);
        chk("err_two", 64'(err_count), 64'd2);

        frame(1'b1, 7'd1, 8'h3C, 16);
        frame(1'b0, 7'd1, 8'h00, 16);
        frame(1'b0, 7'd9, 8'h00, 16);
        frame(1'b0, 7'd0, 8'h00, 16);

        // Reset part-way through a write to reg3: no commit, no error.
        f = {1'b1, 7'd3, 8'h77};
        ncs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 10; i++) begin
            copi = f[15-i];
            wait_clk(6);
            sclk = 1'b1;
            wait_clk(6);
            sclk = 1'b0;
        end
        wait_clk(2);
        rst_n = 1'b0;
        ncs = 1'b1;
        copi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        m_regs = '0;
        m_err = 8'h00;
        m_addr = '0;
        chk("midrst_regs", 64'(regs), 64'd0);
        chk("midrst_err", 64'(err_count), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        frame(1'b1, 7'd3, 8'h11, 16);
        chk("reg3_after_rst", 64'(regs[3*DATA_W +: DATA_W]), 64'h11);

        for (int n = 0; n < 255; n++) frame(1'b1, 7'd0, 8'h00, 1);
        chk("err_at_255", 64'(err_count), 64'd255);
        frame(1'b1, 7'd0, 8'h00, 1);
        chk("err_saturated", 64'(err_count), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI peripheral register bank running entirely in the system clock domain. SCLK, COPI and nCS are synchronised and edge-detected against `clk`. Write frames update a configurable bank of registers; read frames return register contents on CIPO. It replaces the fixed five-register, write-only SPI block and feeds the same downstream configuration logic (PWM/output control) through a flat register bus.

## Interface
- `NUM_REGS`, default 5: number of registers, 1..2^ADDR_W.
- `ADDR_W`, default 7: address field width.
- `DATA_W`, default 8: register and data field width.
- Derived: `FRAME_W = 1 + ADDR_W + DATA_W` (16 at defaults).

Ports:
- `clk` in 1: system clock, sole clock of the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock pin, asynchronous to `clk`.
- `copi` in 1: controller-out data pin.
- `ncs` in 1: chip select pin, active low.
- `cipo` out 1: peripheral-out data.
- `regs` out NUM_REGS*DATA_W: flat register bus; reg i at bits [i*DATA_W +: DATA_W].
- `wr_strobe` out 1: one-cycle pulse on every committed write.
- `wr_addr` out ADDR_W: address of the last committed write.
- `err_count` out 8: count of malformed frames, saturating.

## Operation
- Synchronisers: 2-FF on `sclk`, `copi`, `ncs`. A third registered stage of `sclk`/`ncs` gives rise/fall edge detection.
- SPI mode 0 only:
  - Sample `copi` on synced SCLK rising edge.
  - Change `cipo` on synced SCLK falling edge.
  - All fields MSB first.
- Frame format, in order:
  - bit 0: R/W (1 = write, 0 = read).
  - next ADDR_W bits: address.
  - next DATA_W bits: data.
- States:
  - IDLE: `ncs` high.
  - ADDR: receiving R/W and address.
  - DATA: receiving or sending data.
  - OVER: more than FRAME_W SCLK rising edges seen.
- Transitions:
  - `ncs` fall → ADDR. Bit counter and shift register cleared.
  - ADDR → DATA after the (1+ADDR_W)th rising edge.
  - DATA → OVER on rising edge FRAME_W+1.
  - Any state → IDLE on `ncs` rise.
- Bit counter saturates at FRAME_W+1. Bits after the frame are discarded.
- Commit on `ncs` rise, in IDLE transition cycle:
  - Count == FRAME_W, write, addr < NUM_REGS: reg[addr] <= data; `wr_strobe` = 1; `wr_addr` <= addr.
  - Count == FRAME_W, write, addr ≥ NUM_REGS: silently ignored, no error.
  - Count == FRAME_W, read: no register effect.
  - Count ≠ FRAME_W and count ≠ 0: `err_count` += 1, saturating at 255. Applies to reads and writes alike.
  - Count == 0 (nCS pulse with no clocks): ignored, not an error.
- Read path:
  - On the ADDR→DATA rising edge with R/W = 0, load tx shift register with reg[addr], or 0 if addr ≥ NUM_REGS.
  - `cipo` = tx MSB.
  - Shift left on each subsequent SCLK falling edge while in DATA.
- `cipo` = 0 whenever synced `ncs` is high or state is not DATA.
- Reset values:
  - All regs 0; `wr_strobe` 0; `wr_addr` 0; `err_count` 0; `cipo` 0.
  - State IDLE; counter 0.
  - Synchronisers: `ncs` stages 1, `sclk` and `copi` stages 0.
- Reset mid-frame: the frame is abandoned with no commit and no error count. The next `ncs` fall starts cleanly.

## Timing
- Pin to detected edge: 3 `clk` cycles.
- Requirements on `clk`:
  - SCLK high and low phases each ≥ 3 `clk` periods.
  - `ncs` high between frames ≥ 3 `clk` periods.
- Commit latency: `regs`, `wr_strobe` and `wr_addr` update on the `clk` edge after detected `ncs` rise, about 4 cycles after the pin.
- `wr_strobe` is high exactly 1 cycle per committed write.
- Read data: the first data bit is valid on `cipo` 1 `clk` after the last address rising edge is detected. Each following bit is valid 1 `clk` after a detected falling edge.
- Same-cycle synced `ncs` rise and SCLK rise: `ncs` wins, and the SCLK edge is not counted.
- A write to reg[addr] is committed before any later frame's read latch, so back-to-back frames read the new value.

## Configuration
- `SPI_READBACK_EN` defined:
  - Read frames drive `cipo` as above.
- Not defined:
  - No tx shift register; `cipo` is tied 0.
  - Read frames of correct length are ignored.
  - Length checking and `err_count` behave identically.

## Test plan
- Write R/W = 1, addr 0, data 0xA5, 16 SCLKs → reg0 = 0xA5, `wr_strobe` single-cycle pulse, `wr_addr` = 0, `err_count` = 0.
- Write addr 5, data 0xFF (NUM_REGS = 5) → all regs unchanged, no strobe, `err_count` = 0.
- 15-SCLK write to addr 2, then 17-SCLK write to addr 2 → reg2 unchanged, `err_count` = 2.
- With `SPI_READBACK_EN`: write reg1 = 0x3C, then read addr 1 → `cipo` bits 0,0,1,1,1,1,0,0 across the data phase. Read addr 9 → all zeros.
- Assert `rst_n` low after 10 SCLKs of a write to reg3 = 0x77 → reg3 = 0, `err_count` = 0. A following full write of 0x11 lands.
- 256 one-SCLK frames → `err_count` = 255 (saturates, no wrap).
